// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package arb_pkg;

   localparam int unsigned NUM_REQ      = 8;
   localparam int unsigned IDX_W        = 3;
   localparam int unsigned MAX_HOLD_DEF = 15;

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StRelease
   } arb_state_e;

endpackage

// File: rtl/decoder3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decoder3to8 (
   input  logic [2:0] in,
   input  logic       en,
   output logic [7:0] out
);

   always_comb begin
      out = '0;
      if (en) begin
         out[in] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; grant is held until done, withdrawal or timeout.
// Optional forced release is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               busy,
   output logic               timeout
);

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_hold_range
      $error("MAX_HOLD must be within 1..255");
   end

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             tmo_hit;

   // First set request at or above ptr, wrapping from 7 back to 0.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   p);
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] win;
      logic             found;
      win   = p;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = p + IDX_W'(i);
         if (!found && r[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               idx_d   = rr_pick(req, ptr_q);
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (done || !req[idx_q] || tmo_hit) begin
               state_d = StRelease;
            end
         end
         StRelease: begin
            ptr_d   = idx_q + 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HoldLim = 8'(MAX_HOLD);

   logic [7:0] hold_q, hold_d;
   logic       timeout_q, timeout_d;

   // Fires on the MAX_HOLD-th grant cycle so the grant lasts exactly MAX_HOLD cycles.
   assign tmo_hit = (state_q == StGrant) && ((hold_q + 8'd1) == HoldLim);

   always_comb begin
      hold_d    = hold_q;
      timeout_d = 1'b0;
      if (state_q == StIdle && state_d == StGrant) begin
         hold_d = '0;
      end else if (state_q == StGrant) begin
         hold_d = hold_q + 8'd1;
      end
      // A normal release in the same cycle takes precedence over the forced one.
      if (tmo_hit && !done && req[idx_q]) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   assign gnt_valid = (state_q == StGrant);
   assign busy      = (state_q != StIdle);
   assign gnt_idx   = idx_q;

   decoder3to8 u_dec (
      .in  (idx_q),
      .en  (gnt_valid),
      .out (gnt)
   );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: expected winners are queued at stimulus time
// and checked when gnt_valid rises. Timeout checks follow ARB_TIMEOUT_EN.
module tb_rr_arbiter8;
   import arb_pkg::*;

   localparam int unsigned TbHold = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       busy;
   logic       timeout;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int mon_e;
   bit prev_v = 1'b0;

   always #5 clk = ~clk;

   rr_arbiter8 #(
      .MAX_HOLD (TbHold)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .busy      (busy),
      .timeout   (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      while (!gnt_valid && n < 8) begin
         step();
         n++;
      end
      chk("grant_wait", 32'(gnt_valid), 32'd1);
   endtask

   task automatic serve(input int exp_idx);
      int n;
      exp_q.push_back(exp_idx);
      wait_grant(n);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("rel_done", 32'(gnt_valid), 32'd0);
   endtask

   // Scoreboard consumer: each new grant must match the oldest expected winner.
   always @(negedge clk) begin
      if (gnt_valid && !prev_v) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_idx", 32'(gnt_idx), 32'(mon_e));
            chk("sb_gnt", 32'(gnt), 32'(1) << mon_e);
         end
      end
      prev_v = gnt_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hold_ok;
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst_gnt", 32'(gnt), 32'h00);
      chk("rst_valid", 32'(gnt_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_idx", 32'(gnt_idx), 32'd0);
      chk("rst_tmo", 32'(timeout), 32'd0);
      step();
      chk("idle_busy", 32'(busy), 32'd0);

      // Single request, then ptr=4 is shown by 0x18 picking requester 4.
      req = 8'h08;
      exp_q.push_back(3);
      wait_grant(n);
      chk("t2_latency", 32'(n), 32'd1);
      chk("t2_busy", 32'(busy), 32'd1);
      done = 1'b1;
      step();
      done = 1'b0;
      req  = 8'h00;
      chk("t2_rel_gnt", 32'(gnt), 32'h00);
      chk("t2_rel_busy", 32'(busy), 32'd1);
      step();
      chk("t2_idle_busy", 32'(busy), 32'd0);
      chk("t2_idx_hold", 32'(gnt_idx), 32'd3);
      req = 8'h18;
      serve(4);
      req = 8'h00;

      // Fairness from ptr=0 with every requester active.
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         serve(k % 8);
      end

      // Winner 6 leaves ptr=7; 0x81 then gives 7 followed by 0.
      req = 8'h40;
      serve(6);
      req = 8'h81;
      serve(7);
      serve(0);
      req = 8'h00;

      // Withdrawal without done.
      req = 8'h20;
      exp_q.push_back(5);
      wait_grant(n);
      req = 8'h00;
      step();
      chk("wd_valid", 32'(gnt_valid), 32'd0);
      chk("wd_gnt", 32'(gnt), 32'h00);

      // Reset mid-grant; 0x84 afterwards must pick 2, proving ptr went back to 0.
      req = 8'h04;
      exp_q.push_back(2);
      wait_grant(n);
      rst = 1'b1;
      step();
      chk("rg_gnt", 32'(gnt), 32'h00);
      chk("rg_valid", 32'(gnt_valid), 32'd0);
      chk("rg_busy", 32'(busy), 32'd0);
      chk("rg_idx", 32'(gnt_idx), 32'd0);
      rst = 1'b0;
      req = 8'h84;
      serve(2);
      req = 8'h00;

      // Lone requester wins again after a two-cycle gap.
      req = 8'h02;
      serve(1);
      exp_q.push_back(1);
      wait_grant(n);
      chk("gap", 32'(n), 32'd2);
      done = 1'b1;
      step();
      done = 1'b0;

      // Requester 1 held with no done.
      exp_q.push_back(1);
      wait_grant(n);
`ifdef ARB_TIMEOUT_EN
      hold_ok = 1;
      for (int c = 0; c < int'(TbHold) - 1; c++) begin
         step();
         if (!gnt_valid || timeout) hold_ok = 0;
      end
      chk("tmo_hold", 32'(hold_ok), 32'd1);
      step();
      chk("tmo_pulse", 32'(timeout), 32'd1);
      chk("tmo_gnt", 32'(gnt), 32'h00);
      exp_q.push_back(1);
      step();
      chk("tmo_once", 32'(timeout), 32'd0);
      wait_grant(n);
`else
      hold_ok = 1;
      for (int c = 0; c < 110; c++) begin
         step();
         if (!gnt_valid || timeout || gnt != 8'h02) hold_ok = 0;
      end
      chk("hold_forever", 32'(hold_ok), 32'd1);
`endif
      req = 8'h00;
      step();
      chk("final_rel", 32'(gnt_valid), 32'd0);
      step();
      step();
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
